tag_stream_source: RTL and testbench
====================================

Name: tag_stream_source

Overview:
- Synthesizable transmitter for the time-tag AXI-stream that the combination measurement consumes.
- Converts per-channel event strobes, with sub-cycle fine timestamps, into packed tag beats. Each beat carries up to WORD_WIDTH tags, a per-lane keep, and a lowest-time-bound.
- Sits between the front-end (TDC or detector sampler) and combination_wrapper / histogram consumers. It is the producing end of the same tag interface.

Parameters:
- NUM_OF_CHANNELS, 12, number of event inputs; channel index 0..NUM_OF_CHANNELS-1.
- WORD_WIDTH, 4, tag lanes per output beat.
- FINE_WIDTH, 12, bits of fine timestamp per channel, in ps.
- CLK_PERIOD_PS, 3200, clock period in ps; fine value must be < CLK_PERIOD_PS.
- TIME_WIDTH, 64, tag time width in ps.
- HEARTBEAT_CYCLES, 256, idle cycles before an empty bound-only beat is sent.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_enable  in  1  when low, new events are ignored; the time counter still runs.
- s_event  in  NUM_OF_CHANNELS  per-channel event strobe for this cycle.
- s_fine  in  NUM_OF_CHANNELS*FINE_WIDTH  fine time per channel, lane i at [i*FINE_WIDTH +: FINE_WIDTH].
- m_tvalid  out  1  beat valid.
- m_tready  in  1  consumer ready.
- m_tkeep  out  WORD_WIDTH  lane k holds a valid tag.
- m_tagtime  out  WORD_WIDTH*TIME_WIDTH  tag time in ps per lane.
- m_channel  out  WORD_WIDTH*CH_W  channel index per lane; CH_W = $clog2(NUM_OF_CHANNELS).
- m_lowest_time_bound  out  TIME_WIDTH  no tag emitted later will be earlier than this.
- dropped_events  out  32  saturating count of discarded events.

Behaviour:
- Reset values:
  - m_tvalid=0, m_tkeep=0, m_tagtime=0, m_channel=0, m_lowest_time_bound=0, dropped_events=0.
  - Internal: coarse counter=0, pending bitmap=0, heartbeat counter=0.
- Coarse time:
  - The counter increments every cycle and wraps modulo 2^TIME_WIDTH.
  - base_time = coarse*CLK_PERIOD_PS, kept as an accumulator that adds CLK_PERIOD_PS each cycle (no multiplier).
- Capture stage:
  - Holds a pending bitmap P, fine values F[], and the capture base time B.
  - "Load" = (!m_tvalid || m_tready).
  - Capture condition: s_enable && |s_event && (P==0 || P becomes 0 this cycle through a load).
  - On capture: P<=s_event, F<=s_fine, B<=base_time.
  - If s_enable && |s_event and capture is not possible, all events of that cycle are dropped. dropped_events += popcount(s_event), saturating at 2^32-1.
- State machine:
  - IDLE (P==0) -> DRAIN when a capture occurs.
  - DRAIN -> IDLE when the final load clears P, unless a new capture occurs in that same cycle.
- Beat formation, on load in DRAIN:
  - Take the lowest-indexed up to WORD_WIDTH set bits of P, in ascending channel order, into lanes 0.. upward.
  - tkeep = contiguous ones from lane 0. Unused lanes have tagtime=0, channel=0.
  - Tag time = B + F[ch].
  - m_lowest_time_bound = B.
  - Clear the taken bits from P.
- AXI rules:
  - Once m_tvalid is high, all m_* fields stay stable until m_tready.
  - m_tvalid does not depend combinationally on m_tready.
- Latency: from a strobe cycle to its first beat valid is 2 cycles (capture register, then output register), provided the output register is free.
- Heartbeat:
  - The counter counts cycles with P==0 and no beat loaded. It resets on any load.
  - On reaching HEARTBEAT_CYCLES-1 with Load true, emit a beat with tkeep=0 and m_lowest_time_bound=base_time.
- Monotonicity: m_lowest_time_bound never decreases across beats, except on TIME_WIDTH wrap.
- s_enable low mid-DRAIN: pending tags still drain; only new captures are blocked. This is not counted as dropped.
- Fine value >= CLK_PERIOD_PS: passed through unchanged (the producer's error). An assertion flags it in simulation.
- Reset mid-operation: pending tags and the output beat are discarded, and m_tvalid drops immediately.

Decomposition:
- Package tag_stream_pkg:
  - CH_W function: $clog2 with a minimum of 1.
  - typedef tag_t {time, channel}.
  - Localparam for the heartbeat counter width.
- One sub-module: tag_lane_select. It is combinational: pending bitmap in; up to WORD_WIDTH channel indices, lane-valid mask and remaining bitmap out. It uses a priority-encoder chain.

Test Plan:
- Single event: ch3, fine=100 at coarse cycle 10 with m_tready=1 -> one beat 2 cycles later with tkeep=0001, channel=3, tagtime=10*3200+100=32100, bound=32000.
- Burst: all 12 channels in one cycle, fine=i -> three beats, with channels 0-3, 4-7 and 8-11, all tkeep=1111; dropped_events=0.
- Drop: all 12 channels on cycle n, then ch0 on cycle n+1 while draining -> ch0 discarded; dropped_events=1; the following idle capture works normally.
- Backpressure: m_tready=0 for 20 cycles during the burst -> beat 1 held stable for all 20 cycles; no tag is lost or duplicated after release.
- Heartbeat: no events for 300 cycles -> first empty beat (tkeep=0) appears 256 cycles after the last load, with bound equal to base_time at that cycle; bound values increase across heartbeats.
- Async reset asserted mid-burst -> m_tvalid=0 and dropped_events=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tag_stream_pkg.sv
// Shared sizing helpers, tag record and FSM encoding for the time-tag stream source.
package tag_stream_pkg;

  localparam int DEF_NUM_OF_CHANNELS  = 12;
  localparam int DEF_TIME_WIDTH       = 64;
  localparam int DEF_HEARTBEAT_CYCLES = 256;

  function automatic int ch_w(input int num_of_channels);
    return (num_of_channels > 1) ? $clog2(num_of_channels) : 1;
  endfunction

  localparam int TAG_CH_W = ch_w(DEF_NUM_OF_CHANNELS);
  localparam int HB_W     = $clog2(DEF_HEARTBEAT_CYCLES);

  typedef struct packed {
    logic [DEF_TIME_WIDTH-1:0] tagtime;
    logic [TAG_CH_W-1:0]       channel;
  } tag_t;

  typedef enum logic {IDLE, DRAIN} state_t;

endpackage

// File: rtl/tag_stream_source_lane_select.sv
// Picks the lowest-indexed pending channels, one per output lane, and returns what is left.
module tag_lane_select
  import tag_stream_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = DEF_NUM_OF_CHANNELS,
  parameter int WORD_WIDTH      = 4,
  parameter int CH_W            = ch_w(NUM_OF_CHANNELS)
) (
  input  logic [NUM_OF_CHANNELS-1:0] pending,
  output logic [WORD_WIDTH*CH_W-1:0] lane_ch,
  output logic [WORD_WIDTH-1:0]      lane_valid,
  output logic [NUM_OF_CHANNELS-1:0] remaining
);

  logic [NUM_OF_CHANNELS-1:0] work;
  logic [CH_W-1:0]            sel;

  // Each lane stage encodes the lowest set bit, then strips it for the next stage.
  always_comb begin
    work       = pending;
    sel        = '0;
    lane_ch    = '0;
    lane_valid = '0;
    for (int k = 0; k < WORD_WIDTH; k++) begin
      sel = '0;
      for (int i = NUM_OF_CHANNELS - 1; i >= 0; i--) begin
        if (work[i]) sel = CH_W'(i);
      end
      lane_valid[k]            = |work;
      lane_ch[k*CH_W +: CH_W]  = sel;
      work                     = work & (work - NUM_OF_CHANNELS'(1));
    end
    remaining = work;
  end

endmodule

// File: rtl/tag_stream_source.sv
// Packs per-channel event strobes with fine timestamps into AXI-stream tag beats,
// with a lowest-time-bound per beat and bound-only heartbeats while idle.
module tag_stream_source
  import tag_stream_pkg::*;
#(
  parameter int  NUM_OF_CHANNELS  = DEF_NUM_OF_CHANNELS,
  parameter int  WORD_WIDTH       = 4,
  parameter int  FINE_WIDTH       = 12,
  parameter int  CLK_PERIOD_PS    = 3200,
  parameter int  TIME_WIDTH       = DEF_TIME_WIDTH,
  parameter int  HEARTBEAT_CYCLES = DEF_HEARTBEAT_CYCLES,
  localparam int CH_W             = ch_w(NUM_OF_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_enable,
  input  logic [NUM_OF_CHANNELS-1:0]           s_event,
  input  logic [NUM_OF_CHANNELS*FINE_WIDTH-1:0] s_fine,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [WORD_WIDTH-1:0]                m_tkeep,
  output logic [WORD_WIDTH*TIME_WIDTH-1:0]     m_tagtime,
  output logic [WORD_WIDTH*CH_W-1:0]           m_channel,
  output logic [TIME_WIDTH-1:0]                m_lowest_time_bound,
  output logic [31:0]                          dropped_events
);

  state_t                              state_q, state_d;
  logic [NUM_OF_CHANNELS-1:0]          pend_q, pend_d, remaining;
  logic [NUM_OF_CHANNELS*FINE_WIDTH-1:0] fine_q;
  logic [TIME_WIDTH-1:0]               base_time, cap_base_q;
  logic [HB_W-1:0]                     hb_cnt;
  logic [WORD_WIDTH*CH_W-1:0]          lane_ch;
  logic [WORD_WIDTH-1:0]               lane_valid;
  tag_t                                lane_tag [WORD_WIDTH];
  logic                                load, any_event, drain_load, drain_last;
  logic                                capture, drop, hb_fire;
  logic [32:0]                         drop_sum;

  tag_lane_select #(
    .NUM_OF_CHANNELS (NUM_OF_CHANNELS),
    .WORD_WIDTH      (WORD_WIDTH),
    .CH_W            (CH_W)
  ) u_lane_select (
    .pending    (pend_q),
    .lane_ch    (lane_ch),
    .lane_valid (lane_valid),
    .remaining  (remaining)
  );

  // A capture is allowed when nothing is pending, or when this cycle's load empties the bitmap.
  always_comb begin
    load       = !m_tvalid || m_tready;
    any_event  = s_enable && (|s_event);
    drain_load = (state_q == DRAIN) && load;
    drain_last = drain_load && (remaining == '0);
    capture    = any_event && ((state_q == IDLE) || drain_last);
    drop       = any_event && !capture;
    hb_fire    = (state_q == IDLE) && load && (hb_cnt == HB_W'(HEARTBEAT_CYCLES - 1));
    pend_d     = pend_q;
    state_d    = state_q;
    if (drain_load) pend_d = remaining;
    if (capture)    pend_d = s_event;
    case (state_q)
      IDLE:  if (capture) state_d = DRAIN;
      DRAIN: if (drain_last && !capture) state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, dropped_events};
    for (int i = 0; i < NUM_OF_CHANNELS; i++) drop_sum = drop_sum + 33'(s_event[i]);
  end

  always_comb begin
    for (int k = 0; k < WORD_WIDTH; k++) begin
      lane_tag[k].channel = lane_ch[k*CH_W +: CH_W];
      lane_tag[k].tagtime = '0;
      if (lane_valid[k])
        lane_tag[k].tagtime = cap_base_q +
          TIME_WIDTH'(fine_q[int'(lane_ch[k*CH_W +: CH_W])*FINE_WIDTH +: FINE_WIDTH]);
    end
  end

  // Heartbeat counter idles at its terminal value until the output register can take a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pend_q         <= '0;
      fine_q         <= '0;
      cap_base_q     <= '0;
      base_time      <= '0;
      hb_cnt         <= '0;
      dropped_events <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      base_time <= base_time + TIME_WIDTH'(CLK_PERIOD_PS);
      if (capture) begin
        fine_q     <= s_fine;
        cap_base_q <= base_time;
      end
      if (drop) dropped_events <= drop_sum[32] ? '1 : drop_sum[31:0];
      if (drain_load || hb_fire)
        hb_cnt <= '0;
      else if ((state_q == IDLE) && (hb_cnt != HB_W'(HEARTBEAT_CYCLES - 1)))
        hb_cnt <= hb_cnt + HB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid            <= 1'b0;
      m_tkeep             <= '0;
      m_tagtime           <= '0;
      m_channel           <= '0;
      m_lowest_time_bound <= '0;
    end else if (load) begin
      if (drain_load) begin
        m_tvalid            <= 1'b1;
        m_tkeep             <= lane_valid;
        m_lowest_time_bound <= cap_base_q;
        for (int k = 0; k < WORD_WIDTH; k++) begin
          m_tagtime[k*TIME_WIDTH +: TIME_WIDTH] <= lane_tag[k].tagtime;
          m_channel[k*CH_W +: CH_W]             <= lane_tag[k].channel;
        end
      end else if (hb_fire) begin
        m_tvalid            <= 1'b1;
        m_tkeep             <= '0;
        m_tagtime           <= '0;
        m_channel           <= '0;
        m_lowest_time_bound <= base_time;
      end else begin
        m_tvalid <= 1'b0;
      end
    end
  end

  // Fine values at or beyond one clock period are the producer's fault; flag them.
  for (genvar i = 0; i < NUM_OF_CHANNELS; i++) begin : g_fine_check
    assert property (@(posedge clk) disable iff (rst)
      (s_enable && s_event[i]) |-> (32'(s_fine[i*FINE_WIDTH +: FINE_WIDTH]) < 32'(CLK_PERIOD_PS)));
  end

endmodule

// File: tb/tb_tag_stream_source.sv
// Randomized and directed bench for tag_stream_source against a queue-based reference model.
module tb_tag_stream_source;

  localparam int NCH = 12, WW = 4, FW = 12, PERIOD = 3200, TW = 64, HB = 256, CHW = 4;

  logic               clk = 1'b0, rst = 1'b1, s_enable = 1'b0, m_tready = 1'b0;
  logic [NCH-1:0]     s_event = '0;
  logic [NCH*FW-1:0]  s_fine = '0;
  logic               m_tvalid;
  logic [WW-1:0]      m_tkeep;
  logic [WW*TW-1:0]   m_tagtime;
  logic [WW*CHW-1:0]  m_channel;
  logic [TW-1:0]      m_lowest_time_bound;
  logic [31:0]        dropped_events;

  tag_stream_source dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_enable            (s_enable),
    .s_event             (s_event),
    .s_fine              (s_fine),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready),
    .m_tkeep             (m_tkeep),
    .m_tagtime           (m_tagtime),
    .m_channel           (m_channel),
    .m_lowest_time_bound (m_lowest_time_bound),
    .dropped_events      (dropped_events)
  );

  always #5 clk = ~clk;

  int check_count = 0, error_count = 0, cyc = 0, last_data_cyc = 0;
  int hb_cyc[$];
  logic [63:0] hb_bound[$];

  // Reference model: pending tags are a queue of channel numbers in ascending order.
  int          mq[$];
  int          m_fine[NCH];
  logic [63:0] m_cap_base, m_base, m_bound;
  logic        m_valid;
  logic [3:0]  m_keep;
  logic [255:0] m_time;
  logic [15:0] m_ch;
  int          m_hb;
  longint      m_drops;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_cap_base = '0; m_base = '0; m_bound = '0;
    m_valid = 1'b0; m_keep = '0; m_time = '0; m_ch = '0;
    m_hb = 0; m_drops = 0;
  endtask

  task automatic modelStep(input logic [NCH-1:0] ev, input logic [NCH*FW-1:0] fine,
                           input logic en, input logic ready);
    int c;
    if (!m_valid || ready) begin
      if (mq.size() > 0) begin
        m_valid = 1'b1; m_keep = '0; m_time = '0; m_ch = '0; m_bound = m_cap_base;
        for (int k = 0; k < WW; k++) begin
          if (mq.size() > 0) begin
            c = mq.pop_front();
            m_keep[k] = 1'b1;
            m_time[k*TW +: TW] = m_cap_base + 64'(m_fine[c]);
            m_ch[k*CHW +: CHW] = 4'(c);
          end
        end
        m_hb = 0;
      end else if (m_hb == HB - 1) begin
        m_valid = 1'b1; m_keep = '0; m_time = '0; m_ch = '0; m_bound = m_base;
        m_hb = 0;
      end else begin
        m_valid = 1'b0;
        m_hb++;
      end
    end else if (mq.size() == 0 && m_hb < HB - 1) begin
      m_hb++;
    end
    if (en && ev != '0) begin
      if (mq.size() == 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (ev[i]) begin
            mq.push_back(i);
            m_fine[i] = int'(fine[i*FW +: FW]);
          end
        end
        m_cap_base = m_base;
      end else begin
        m_drops = m_drops + $countones(ev);
        if (m_drops > 64'hFFFF_FFFF) m_drops = 64'hFFFF_FFFF;
      end
    end
    m_base = m_base + 64'(PERIOD);
  endtask

  task automatic compareModel();
    checkOutput("tvalid", 256'(m_tvalid), 256'(m_valid));
    if (m_valid) begin
      checkOutput("tkeep", 256'(m_tkeep), 256'(m_keep));
      checkOutput("tagtime", 256'(m_tagtime), m_time);
      checkOutput("channel", 256'(m_channel), 256'(m_ch));
      checkOutput("bound", 256'(m_lowest_time_bound), 256'(m_bound));
    end
    checkOutput("dropped", 256'(dropped_events), 256'(m_drops));
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] ev, input logic [NCH*FW-1:0] fine,
                               input logic en, input logic ready);
    s_event = ev; s_fine = fine; s_enable = en; m_tready = ready;
    @(posedge clk);
    modelStep(ev, fine, en, ready);
    #1;
    compareModel();
    if (m_tvalid && m_tkeep != '0) last_data_cyc = cyc;
    if (m_tvalid && m_tkeep == '0) begin
      hb_cyc.push_back(cyc);
      hb_bound.push_back(m_lowest_time_bound);
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b1, ready);
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    cyc = 0;
  endtask

  initial begin
    logic [NCH*FW-1:0] f, f_burst;
    logic [NCH-1:0]    ev;
    int                cyc_burst;

    modelReset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 256'(m_tvalid), 256'(0));
    checkOutput("rst_tkeep", 256'(m_tkeep), 256'(0));
    checkOutput("rst_tagtime", 256'(m_tagtime), 256'(0));
    checkOutput("rst_channel", 256'(m_channel), 256'(0));
    checkOutput("rst_bound", 256'(m_lowest_time_bound), 256'(0));
    checkOutput("rst_dropped", 256'(dropped_events), 256'(0));
    rst = 1'b0;
    cyc = 0;

    // Single event on channel 3 during coarse cycle 10.
    idle(10, 1'b1);
    f = '0; f[3*FW +: FW] = 12'd100;
    applyStimulus(12'h008, f, 1'b1, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("single_tvalid", 256'(m_tvalid), 256'(1));
    checkOutput("single_tkeep", 256'(m_tkeep), 256'(4'b0001));
    checkOutput("single_channel", 256'(m_channel[3:0]), 256'(3));
    checkOutput("single_tagtime", 256'(m_tagtime[63:0]), 256'(64'd32100));
    checkOutput("single_bound", 256'(m_lowest_time_bound), 256'(64'd32000));

    // All channels at once drain as three full beats.
    for (int i = 0; i < NCH; i++) f_burst[i*FW +: FW] = FW'(i);
    cyc_burst = cyc;
    applyStimulus({NCH{1'b1}}, f_burst, 1'b1, 1'b1);
    for (int b = 0; b < 3; b++) begin
      applyStimulus('0, '0, 1'b1, 1'b1);
      checkOutput("burst_tkeep", 256'(m_tkeep), 256'(4'hF));
      checkOutput("burst_lane0_ch", 256'(m_channel[3:0]), 256'(4 * b));
      checkOutput("burst_lane0_time", 256'(m_tagtime[63:0]), 256'(longint'(cyc_burst) * PERIOD + 4 * b));
    end
    checkOutput("burst_dropped", 256'(dropped_events), 256'(0));

    // An event while the burst drains is dropped; the next idle capture works.
    applyStimulus({NCH{1'b1}}, f_burst, 1'b1, 1'b1);
    applyStimulus(12'h001, f_burst, 1'b1, 1'b1);
    idle(3, 1'b1);
    checkOutput("drop_count", 256'(dropped_events), 256'(1));
    f = '0; f[5*FW +: FW] = 12'd777;
    applyStimulus(12'h020, f, 1'b1, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b1);
    checkOutput("post_drop_tvalid", 256'(m_tvalid), 256'(1));
    checkOutput("post_drop_tkeep", 256'(m_tkeep), 256'(4'b0001));
    checkOutput("post_drop_channel", 256'(m_channel[3:0]), 256'(5));

    // Backpressure: first beat held for 20 cycles, then released.
    applyStimulus({NCH{1'b1}}, f_burst, 1'b1, 1'b1);
    applyStimulus('0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("hold_tvalid", 256'(m_tvalid), 256'(1));
      checkOutput("hold_channel", 256'(m_channel), 256'(16'h3210));
    end
    idle(5, 1'b1);

    // Heartbeats while idle.
    hb_cyc.delete();
    hb_bound.delete();
    idle(600, 1'b1);
    checkOutput("hb_count", 256'(hb_cyc.size()), 256'(2));
    if (hb_cyc.size() >= 2) begin
      checkOutput("hb_gap", 256'(hb_cyc[0] - last_data_cyc), 256'(HB));
      checkOutput("hb_bound0", 256'(hb_bound[0]), 256'(longint'(hb_cyc[0]) * PERIOD));
      checkOutput("hb_bound_rises", 256'(hb_bound[1] > hb_bound[0]), 256'(1));
    end

    // Randomized traffic with enable gaps and backpressure.
    for (int n = 0; n < 3000; n++) begin
      ev = ($urandom_range(0, 3) == 0) ? (NCH'($urandom) & NCH'($urandom)) : '0;
      for (int i = 0; i < NCH; i++) f[i*FW +: FW] = FW'($urandom_range(0, PERIOD - 1));
      applyStimulus(ev, f, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of a held burst.
    idle(20, 1'b1);
    applyStimulus({NCH{1'b1}}, f_burst, 1'b1, 1'b1);
    applyStimulus(12'h001, f_burst, 1'b1, 1'b0);
    idle(2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_tvalid", 256'(m_tvalid), 256'(0));
    checkOutput("async_rst_dropped", 256'(dropped_events), 256'(0));
    checkOutput("async_rst_bound", 256'(m_lowest_time_bound), 256'(0));
    releaseReset();
    for (int n = 0; n < 500; n++) begin
      ev = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
      for (int i = 0; i < NCH; i++) f[i*FW +: FW] = FW'($urandom_range(0, PERIOD - 1));
      applyStimulus(ev, f, 1'b1, ($urandom_range(0, 1) != 0));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
